mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_rr2.sv | 45 ++++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner types and default widths
// for the IF/LS memory arbiter and its round-robin grant unit.
package mem_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 64;
    localparam int DEF_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } arbState_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-requester round-robin grant with last-grant register.
// Ports: clk, rst (async active-low), reqIf/reqLs in, update in
// (commit current grant), grantIf/grantLs out (combinational, one-hot).
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic reqIf,
    input  logic reqLs,
    input  logic update,
    output logic grantIf,
    output logic grantLs
);

    owner_t lastGrant;

    // On a conflict the requester that did not win last time wins now.
    always_comb begin
        grantIf = 1'b0;
        grantLs = 1'b0;
        unique case (1'b1)
            (reqIf && !reqLs): grantIf = 1'b1;
            (!reqIf && reqLs): grantLs = 1'b1;
            (reqIf && reqLs): begin
                if (lastGrant == OWN_LS) begin
                    grantIf = 1'b1;
                end else begin
                    grantLs = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Resetting to LS makes IF the winner of the first conflict.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lastGrant <= OWN_LS;
        end else if (update) begin
            lastGrant <= grantLs ? OWN_LS : OWN_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch (IF) and load/store
// (LS) with a single outstanding transaction (IDLE->REQ->WAIT->RESP).
// Ports: clk, rst (async active-low); if_req_*/if_resp_* fetch side;
// ls_req_*/ls_resp_* load/store side; mem_req_*/mem_resp_* memory side.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
)(
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    if_req_valid,
    output logic                    if_req_ready,
    input  logic [ADDR_WIDTH-1:0]   if_req_addr,
    output logic                    if_resp_valid,
    output logic [DATA_WIDTH-1:0]   if_resp_data,

    input  logic                    ls_req_valid,
    output logic                    ls_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ls_req_addr,
    input  logic                    ls_req_wen,
    input  logic [DATA_WIDTH-1:0]   ls_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] ls_req_wmask,
    output logic                    ls_resp_valid,
    output logic [DATA_WIDTH-1:0]   ls_resp_data,

    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic                    mem_req_wen,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_req_wmask,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_resp_data
);

    arbState_t               state;
    owner_t                  owner;
    logic [ADDR_WIDTH-1:0]   addrQ;
    logic                    wenQ;
    logic [DATA_WIDTH-1:0]   wdataQ;
    logic [DATA_WIDTH/8-1:0] wmaskQ;
    logic [DATA_WIDTH-1:0]   respDataQ;
    logic                    memReqValidQ;
    logic                    ifRespValidQ;
    logic                    lsRespValidQ;

    logic idle;
    logic grantIf;
    logic grantLs;
    logic accept;

    // rst gates the ready path so readies drop the instant reset asserts.
    assign idle = rst && (state == IDLE);

    arb_rr2 uArb (
        .clk     (clk),
        .rst     (rst),
        .reqIf   (if_req_valid && idle),
        .reqLs   (ls_req_valid && idle),
        .update  (accept),
        .grantIf (grantIf),
        .grantLs (grantLs)
    );

    // A grant only exists for a valid requester, so grant == handshake.
    assign accept       = grantIf || grantLs;
    assign if_req_ready = grantIf;
    assign ls_req_ready = grantLs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            owner        <= OWN_IF;
            addrQ        <= '0;
            wenQ         <= 1'b0;
            wdataQ       <= '0;
            wmaskQ       <= '0;
            respDataQ    <= '0;
            memReqValidQ <= 1'b0;
            ifRespValidQ <= 1'b0;
            lsRespValidQ <= 1'b0;
        end else begin
            ifRespValidQ <= 1'b0;
            lsRespValidQ <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state        <= REQ;
                        memReqValidQ <= 1'b1;
                        owner        <= grantLs ? OWN_LS : OWN_IF;
                        addrQ        <= grantLs ? ls_req_addr : if_req_addr;
                        wenQ         <= grantLs && ls_req_wen;
                        wdataQ       <= grantLs ? ls_req_wdata : '0;
                        wmaskQ       <= grantLs ? ls_req_wmask : '0;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state        <= WAIT;
                        memReqValidQ <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        state        <= RESP;
                        respDataQ    <= mem_resp_data;
                        ifRespValidQ <= (owner == OWN_IF);
                        lsRespValidQ <= (owner == OWN_LS);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem_req_valid = memReqValidQ;
    assign mem_req_addr  = addrQ;
    assign mem_req_wen   = wenQ;
    assign mem_req_wdata = wdataQ;
    assign mem_req_wmask = wmaskQ;

    assign if_resp_valid = ifRespValidQ;
    assign ls_resp_valid = lsRespValidQ;
    assign if_resp_data  = respDataQ;
    assign ls_resp_data  = respDataQ;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a small
// memory responder model and directed request vectors.
module tb_mem_arbiter;

    typedef struct {
        bit          isLs;
        bit          careData;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_valid = 1'b0;
    logic        if_req_ready;
    logic [63:0] if_req_addr = '0;
    logic        if_resp_valid;
    logic [63:0] if_resp_data;
    logic        ls_req_valid = 1'b0;
    logic        ls_req_ready;
    logic [63:0] ls_req_addr = '0;
    logic        ls_req_wen = 1'b0;
    logic [63:0] ls_req_wdata = '0;
    logic [7:0]  ls_req_wmask = '0;
    logic        ls_resp_valid;
    logic [63:0] ls_resp_data;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;

    int   nChecks = 0;
    int   nFails = 0;
    int   cyc = 0;
    exp_t expQ[$];

    int          stallLeft = 0;
    int          respDelay = 0;
    bit          strayReq = 1'b0;
    logic [63:0] strayData = 64'hFFFF_0000_FFFF_0000;

    mem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_valid   (if_req_valid),
        .if_req_ready   (if_req_ready),
        .if_req_addr    (if_req_addr),
        .if_resp_valid  (if_resp_valid),
        .if_resp_data   (if_resp_data),
        .ls_req_valid   (ls_req_valid),
        .ls_req_ready   (ls_req_ready),
        .ls_req_addr    (ls_req_addr),
        .ls_req_wen     (ls_req_wen),
        .ls_req_wdata   (ls_req_wdata),
        .ls_req_wmask   (ls_req_wmask),
        .ls_resp_valid  (ls_resp_valid),
        .ls_resp_data   (ls_resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] memWord(input logic [63:0] a);
        case (a)
            64'h8000_0000: return 64'h0000_0000_0000_0413;
            64'h8000_0004: return 64'h0000_0000_0010_0093;
            64'h8000_0008: return 64'h0000_0000_00A0_0113;
            64'h8000_2000: return 64'h1122_3344_5566_7788;
            default:       return a ^ 64'h5A5A_5A5A_5A5A_5A5A;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: ready after stallLeft REQ cycles, response
    // respDelay cycles after the accepted request.
    initial begin
        bit          hs;
        int          pend;
        logic [63:0] pAddr;
        pend  = -1;
        pAddr = '0;
        forever begin
            @(posedge clk);
            hs = mem_req_valid && mem_req_ready;
            if (hs) pAddr = mem_req_addr;
            #2;
            mem_resp_valid = 1'b0;
            if (!rst) begin
                pend          = -1;
                mem_req_ready = 1'b0;
            end else begin
                if (hs) pend = respDelay;
                if (pend == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = memWord(pAddr);
                    pend           = -1;
                end else if (pend > 0) begin
                    pend--;
                end
                if (strayReq) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = strayData;
                    strayReq       = 1'b0;
                end
                if (mem_req_valid && stallLeft > 0) begin
                    mem_req_ready = 1'b0;
                    stallLeft--;
                end else begin
                    mem_req_ready = mem_req_valid;
                end
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_resp_valid || ls_resp_valid) begin
                check("resp one-hot", {63'b0, if_resp_valid && ls_resp_valid}, 64'd0);
                if (expQ.size() == 0) begin
                    check("unexpected resp", {62'b0, if_resp_valid, ls_resp_valid}, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    check("resp owner", {63'b0, ls_resp_valid}, {63'b0, e.isLs});
                    check("resp cycle", 64'(cyc), 64'(e.cyc));
                    if (e.careData) begin
                        check("resp data", if_resp_valid ? if_resp_data : ls_resp_data, e.data);
                    end
                end
            end
        end
    end

    task automatic waitGrant(input string name, input bit expLs, output int c);
        bit got;
        got = 1'b0;
        c   = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (if_req_ready || ls_req_ready) begin
                got = 1'b1;
                c   = cyc;
                check($sformatf("%s grant", name), {62'b0, if_req_ready, ls_req_ready},
                      expLs ? 64'd1 : 64'd2);
            end
        end
        if (!got) check($sformatf("%s grant timeout", name), 64'd0, 64'd1);
    endtask

    task automatic pushExp(input bit isLs, input bit careData,
                           input logic [63:0] data, input int c);
        exp_t e;
        e.isLs     = isLs;
        e.careData = careData;
        e.data     = data;
        e.cyc      = c;
        expQ.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            check($sformatf("%s drain timeout", name), 64'(expQ.size()), 64'd0);
            expQ.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        int c1;

        // Reset with a pending fetch: everything must stay low.
        if_req_valid = 1'b1;
        if_req_addr  = 64'h8000_0000;
        repeat (2) @(negedge clk);
        check("rst if_ready", {63'b0, if_req_ready}, 64'd0);
        check("rst mem_req_valid", {63'b0, mem_req_valid}, 64'd0);
        check("rst resp valids", {62'b0, if_resp_valid, ls_resp_valid}, 64'd0);
        check("rst resp data", if_resp_data, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single fetch, granted in first cycle after release.
        waitGrant("fetch", 1'b0, c);
        pushExp(1'b0, 1'b1, 64'h0000_0413, c + 3);
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        @(negedge clk);
        check("fetch mem_req_valid", {63'b0, mem_req_valid}, 64'd1);
        check("fetch mem_req_addr", mem_req_addr, 64'h8000_0000);
        check("fetch wen/wmask", {55'b0, mem_req_wen, mem_req_wmask}, 64'd0);
        drain("fetch");
        @(negedge clk);
        check("hold resp data", if_resp_data, 64'h0000_0413);

        // Conflicts after a fresh reset: IF, LS, then IF again.
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst          = 1'b1;
        if_req_valid = 1'b1;
        if_req_addr  = 64'h8000_0004;
        ls_req_valid = 1'b1;
        ls_req_addr  = 64'h8000_2000;
        ls_req_wen   = 1'b0;
        waitGrant("conflict1", 1'b0, c1);
        pushExp(1'b0, 1'b1, 64'h0000_0000_0010_0093, c1 + 3);
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        waitGrant("conflict2", 1'b1, c);
        check("conflict2 cycle", 64'(c), 64'(c1 + 4));
        pushExp(1'b1, 1'b1, 64'h1122_3344_5566_7788, c + 3);
        @(posedge clk);
        #1;
        ls_req_valid = 1'b0;
        drain("conflict2");
        if_req_valid = 1'b1;
        if_req_addr  = 64'h8000_0008;
        ls_req_valid = 1'b1;
        waitGrant("conflict3", 1'b0, c);
        pushExp(1'b0, 1'b1, 64'h0000_0000_00A0_0113, c + 3);
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        waitGrant("conflict4", 1'b1, c);
        pushExp(1'b1, 1'b1, 64'h1122_3344_5566_7788, c + 3);
        @(posedge clk);
        #1;
        ls_req_valid = 1'b0;
        drain("conflict4");

        // Store with three stalled REQ cycles.
        ls_req_valid = 1'b1;
        ls_req_addr  = 64'h8000_1000;
        ls_req_wen   = 1'b1;
        ls_req_wdata = 64'h0000_0000_DEAD_BEEF;
        ls_req_wmask = 8'h0F;
        stallLeft    = 3;
        waitGrant("store", 1'b1, c);
        pushExp(1'b1, 1'b0, 64'd0, c + 6);
        @(posedge clk);
        #1;
        ls_req_valid = 1'b0;
        ls_req_wen   = 1'b0;
        ls_req_wdata = '0;
        ls_req_wmask = '0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("store valid %0d", k), {63'b0, mem_req_valid}, 64'd1);
            check($sformatf("store addr %0d", k), mem_req_addr, 64'h8000_1000);
            check($sformatf("store wdata %0d", k), mem_req_wdata, 64'h0000_0000_DEAD_BEEF);
            check($sformatf("store wen/wmask %0d", k),
                  {55'b0, mem_req_wen, mem_req_wmask}, 64'h10F);
        end
        drain("store");

        // Stray response while idle.
        strayReq = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stray idle %0d", k),
                  {61'b0, if_resp_valid, ls_resp_valid, mem_req_valid}, 64'd0);
        end

        // Stray response while the request is stalled in REQ.
        @(posedge clk);
        #1;
        if_req_valid = 1'b1;
        if_req_addr  = 64'h8000_0008;
        stallLeft    = 2;
        waitGrant("strayreq", 1'b0, c);
        pushExp(1'b0, 1'b1, 64'h0000_0000_00A0_0113, c + 5);
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        strayReq     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("stray in REQ keeps req", {62'b0, mem_req_valid, if_resp_valid}, 64'd2);
        drain("strayreq");

        // Reset while waiting for the memory response.
        respDelay    = 4;
        if_req_valid = 1'b1;
        if_req_addr  = 64'h8000_0004;
        waitGrant("abort", 1'b0, c);
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        @(posedge clk);
        #1;
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        rst          = 1'b0;
        #1;
        check("abort outputs", {58'b0, if_req_ready, ls_req_ready, mem_req_valid,
                                if_resp_valid, ls_resp_valid, 1'b0}, 64'd0);
        check("abort resp data", ls_resp_data, 64'd0);
        respDelay = 0;
        ls_req_valid = 1'b0;
        if_req_addr  = 64'h8000_0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        waitGrant("after abort", 1'b0, c);
        pushExp(1'b0, 1'b1, 64'h0000_0413, c + 3);
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        drain("after abort");

        repeat (5) @(negedge clk);
        check("scoreboard empty", 64'(expQ.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", nFails);
        $fatal(1, "watchdog");
    end

endmodule
